sdram_rv_bridge: RTL and testbench
==================================

Name: sdram_rv_bridge

Overview:
- Upstream adapter feeding the RISC-V port of the NES SDRAM controller.
- Converts a 32-bit valid/ready softcore memory bus into one or two 16-bit toggle-handshake transactions on the controller's RV port: rv_addr, rv_din, rv_ds, rv_we, rv_req/rv_req_ack, rv_dout.
- Presents a 2MB, bank-2 word space to the CPU.

Parameters:
- RD_WAIT, 3: clk cycles after ack match before rv_dout is sampled. Covers the controller's late read-data update.
- ADDR_MASK, 32'h001F_FFFF: CPU address bits forwarded. Higher bits are ignored.

Ports:
- clk  in  1  SDRAM clock, same as controller clk
- resetn  in  1  sync active-low reset
- mem_valid  in  1  CPU request; held until mem_ready
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- sdram_busy  in  1  controller busy (init in progress)
- rv_addr  out  20  halfword address [20:1] to controller
- rv_din  out  16  halfword write data
- rv_ds  out  2  byte selects {hi,lo}
- rv_we  out  1  write flag
- rv_req  out  1  toggle request
- rv_req_ack  in  1  toggle acknowledge from controller
- rv_dout  in  16  read halfword from controller

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, rv_addr=0, rv_din=0, rv_ds=0, rv_we=0, rv_req=0. State goes to SYNC.
- The controller's ack is not reset, so SYNC copies rv_req<=rv_req_ack in one cycle, then moves to IDLE.
- A request is pending while rv_req!=rv_req_ack.
- States: SYNC, IDLE, ISSUE, WAIT_ACK, WAIT_DATA, DONE.
- IDLE: when mem_valid=1, mem_ready=0 and sdram_busy=0, latch mem_addr/mem_wdata/mem_wstrb.
  - Select halves:
    - Write: lo half needed if wstrb[1:0]!=0; hi half needed if wstrb[3:2]!=0.
    - Read: both halves.
  - Go to ISSUE with the lowest needed half.
- ISSUE (1 cycle):
  - rv_addr={addr[20:2],half}
  - rv_we=(wstrb!=0)
  - rv_din = wdata[15:0] or wdata[31:16]
  - rv_ds = matching wstrb pair on write, 2'b11 on read
  - toggle rv_req
  - go to WAIT_ACK
- rv_* outputs are held stable from ISSUE until the ack matches.
- WAIT_ACK: stay while rv_req!=rv_req_ack.
  - On match: write → next half or DONE.
  - On match: read → WAIT_DATA.
- WAIT_DATA: count RD_WAIT cycles, then capture rv_dout into mem_rdata[15:0] (half 0) or [31:16] (half 1). Then go to the next half or DONE.
- DONE: mem_ready=1 for exactly one cycle, then IDLE. mem_ready is never asserted twice for one request.
- Latency:
  - read = 2×(1 + ack latency + RD_WAIT) + 1 cycles
  - write of both halves = 2×(1 + ack latency) + 1 cycles
- mem_rdata holds its last value after DONE. It is unchanged by writes.
- Writes never read-modify-write; partial bytes go through rv_ds only.
- sdram_busy rising mid-transaction has no effect; the in-flight sequence completes.
- Reset mid-transaction: the transaction is abandoned with no mem_ready. The bridge resyncs via SYNC, and any late controller ack is absorbed by the copy.
- mem_valid dropping before mem_ready is a CPU protocol violation. The bridge completes the latched transaction anyway.

Optional Feature:
- Macro: SDRAM_RV_RDCACHE_EN.
- With it defined:
  - One-entry read cache: tag=addr[20:2], 32-bit data, valid bit; cleared on reset.
  - Read hit in IDLE → DONE next cycle (mem_ready 2 cycles after mem_valid), no SDRAM traffic.
  - Read miss fills the entry on completion.
  - A write to the tagged word merges the enabled bytes into the cached data.
- Without it: every read goes to SDRAM; no tag/data registers are synthesized.

Test Plan:
- Reset/resync: controller model holds rv_req_ack=1 at reset release → rv_req=1 after SYNC; no toggle until a request arrives.
- Full read: mem_addr=0x0000_1004, ack after 4 cycles, model drives rv_dout 0xBEEF (rv_addr=0x00802) then 0xDEAD (rv_addr=0x00803), RD_WAIT=3 → mem_rdata=0xDEADBEEF, one mem_ready pulse, two rv_req toggles, rv_ds=2'b11.
- Partial write: wstrb=4'b1100, wdata=0x12345678, addr 0x8 → single transaction, rv_addr=0x00005, rv_din=0x1234, rv_ds=2'b11, rv_we=1.
- Byte write: wstrb=4'b0001 → single transaction on lo half, rv_ds=2'b01, rv_din=0x5678.
- Busy gating: sdram_busy=1 with mem_valid=1 for 50 cycles → no rv_req toggle. Release → transaction starts the next cycle.
- Reset mid-read: assert resetn=0 in WAIT_ACK, model acks later → after reset no mem_ready; the next read completes correctly. With SDRAM_RV_RDCACHE_EN, repeat a read of the same address → no rv_req toggle, mem_ready 2 cycles after mem_valid.

Source files
------------

// File: rtl/sdram_rv_bridge_if.sv
// Signal bundle between a 32-bit valid/ready CPU bus and the SDRAM controller's
// 16-bit toggle-handshake RV port. The slave view is the bridge; the master view is its environment.
interface sdram_rv_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sdram_busy;
    logic [19:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, sdram_busy, rv_req_ack, rv_dout,
        input  mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, sdram_busy, rv_req_ack, rv_dout,
        output mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req
    );
endinterface

// File: rtl/sdram_rv_bridge.sv
// Splits 32-bit CPU accesses into one or two 16-bit toggle-handshake transactions on the
// controller RV port. Optional one-entry read cache enabled by macro SDRAM_RV_RDCACHE_EN.
module sdram_rv_bridge #(
    parameter int unsigned RD_WAIT   = 3,
    parameter logic [31:0] ADDR_MASK = 32'h001F_FFFF
) (
    input logic              clk,
    input logic              resetn,
    sdram_rv_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        SYNC      = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DATA = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [18:0] word_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        half_r;
    logic [7:0]  wait_cnt_r;
    logic        mem_ready_r;
    logic [31:0] mem_rdata_r;
    logic [19:0] rv_addr_r;
    logic [15:0] rv_din_r;
    logic [1:0]  rv_ds_r;
    logic        rv_we_r;
    logic        rv_req_r;

    logic [31:0] masked_s;
    logic        unused_s;
    logic        accept_s, pending_s, is_read_s, last_half_s, wait_done_s, hit_s;

    assign masked_s    = bus.mem_addr & ADDR_MASK;
    assign unused_s    = ^{masked_s[31:21], masked_s[1:0]};
    assign pending_s   = (rv_req_r != bus.rv_req_ack);
    // mem_ready high means this request was just answered and must not be re-accepted
    assign accept_s    = bus.mem_valid && !mem_ready_r && !bus.sdram_busy;
    assign is_read_s   = (wstrb_r == 4'd0);
    assign last_half_s = half_r || (!is_read_s && (wstrb_r[3:2] == 2'b00));
    assign wait_done_s = (wait_cnt_r == 8'(RD_WAIT - 1));

`ifdef SDRAM_RV_RDCACHE_EN
    logic [18:0] tag_r;
    logic [31:0] cdata_r;
    logic        cvld_r;

    assign hit_s = cvld_r && (bus.mem_wstrb == 4'd0) && (tag_r == masked_s[20:2]);

    // Cache fill on read completion, byte merge on writes to the cached word
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cvld_r  <= 1'b0;
            tag_r   <= 19'd0;
            cdata_r <= 32'd0;
        end else if (state_r == DONE) begin
            if (is_read_s) begin
                cvld_r  <= 1'b1;
                tag_r   <= word_r;
                cdata_r <= mem_rdata_r;
            end else if (cvld_r && (tag_r == word_r)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_r[b]) cdata_r[8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_r <= SYNC;
        else         state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            SYNC:      state_s = IDLE;
            IDLE: begin
                if (accept_s) state_s = hit_s ? DONE : ISSUE;
                else          state_s = IDLE;
            end
            ISSUE:     state_s = WAIT_ACK;
            WAIT_ACK: begin
                if (pending_s)        state_s = WAIT_ACK;
                else if (is_read_s)   state_s = WAIT_DATA;
                else if (last_half_s) state_s = DONE;
                else                  state_s = ISSUE;
            end
            WAIT_DATA: begin
                if (!wait_done_s)     state_s = WAIT_DATA;
                else if (last_half_s) state_s = DONE;
                else                  state_s = ISSUE;
            end
            DONE:      state_s = IDLE;
            default:   state_s = SYNC;
        endcase
    end

    // Request latch, RV port drive and read-data capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_r      <= 19'd0;
            wdata_r     <= 32'd0;
            wstrb_r     <= 4'd0;
            half_r      <= 1'b0;
            wait_cnt_r  <= 8'd0;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'd0;
            rv_addr_r   <= 20'd0;
            rv_din_r    <= 16'd0;
            rv_ds_r     <= 2'b00;
            rv_we_r     <= 1'b0;
            rv_req_r    <= 1'b0;
        end else begin
            mem_ready_r <= (state_r == DONE);
            case (state_r)
                SYNC: rv_req_r <= bus.rv_req_ack;
                IDLE: begin
                    if (accept_s) begin
                        word_r     <= masked_s[20:2];
                        wdata_r    <= bus.mem_wdata;
                        wstrb_r    <= bus.mem_wstrb;
                        // a write with no low byte enabled starts on the high half
                        half_r     <= (bus.mem_wstrb != 4'd0) && (bus.mem_wstrb[1:0] == 2'b00);
                        wait_cnt_r <= 8'd0;
`ifdef SDRAM_RV_RDCACHE_EN
                        if (hit_s) mem_rdata_r <= cdata_r;
`endif
                    end
                end
                ISSUE: begin
                    rv_addr_r  <= {word_r, half_r};
                    rv_we_r    <= !is_read_s;
                    rv_din_r   <= half_r ? wdata_r[31:16] : wdata_r[15:0];
                    rv_ds_r    <= is_read_s ? 2'b11 : (half_r ? wstrb_r[3:2] : wstrb_r[1:0]);
                    rv_req_r   <= ~rv_req_r;
                    wait_cnt_r <= 8'd0;
                end
                WAIT_ACK: begin
                    if (!pending_s && !is_read_s) half_r <= 1'b1;
                end
                WAIT_DATA: begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                    if (wait_done_s) begin
                        if (half_r) mem_rdata_r[31:16] <= bus.rv_dout;
                        else        mem_rdata_r[15:0]  <= bus.rv_dout;
                        half_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.rv_addr   = rv_addr_r;
    assign bus.rv_din    = rv_din_r;
    assign bus.rv_ds     = rv_ds_r;
    assign bus.rv_we     = rv_we_r;
    assign bus.rv_req    = rv_req_r;
endmodule

// File: tb/tb_sdram_rv_bridge.sv
// Self-checking bench for sdram_rv_bridge: toggle-handshake controller model with late read
// data, word-level reference memory, and directed plus randomized CPU accesses.
module tb_sdram_rv_bridge;
    localparam int RD_WAIT = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sdram_rv_bridge_if bus();

    sdram_rv_bridge #(.RD_WAIT(RD_WAIT), .ADDR_MASK(32'h001F_FFFF)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
        logic [1:0]  ds;
        logic        we;
    } tx_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    tx_t         tx_q[$];
    bit [15:0]   sdram [int];
    bit [31:0]   ref_mem [int];
    bit [31:0]   last_rd = 32'h0;
    int          ack_lat = 4;
    bit          model_en = 1'b0;
    bit          rc_vld = 1'b0;
    int          rc_tag = 0;

    // Controller model: acks after ack_lat cycles, read data lands 3 cycles after the ack
    initial begin : ctl_model
        tx_t      t;
        int       key;
        bit [15:0] h;
        bus.rv_req_ack = 1'b1;
        bus.rv_dout    = 16'h0;
        forever begin
            @(negedge clk);
            if (model_en && resetn && (bus.rv_req !== bus.rv_req_ack)) begin
                t.a = bus.rv_addr; t.d = bus.rv_din; t.ds = bus.rv_ds; t.we = bus.rv_we;
                tx_q.push_back(t);
                for (int i = 1; i < ack_lat; i++) begin
                    @(negedge clk);
                    if (resetn) begin
                        n_tests++;
                        if ({bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req} !==
                            {t.a, t.d, t.ds, t.we, ~bus.rv_req_ack}) begin
                            n_fail++;
                            $display("FAIL rv_stable: got %h/%h/%b/%b want %h/%h/%b/%b",
                                     bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, t.a, t.d, t.ds, t.we);
                        end
                    end
                end
                key = int'(t.a);
                h = sdram.exists(key) ? sdram[key] : 16'h0;
                if (t.we) begin
                    if (t.ds[0]) h[7:0]  = t.d[7:0];
                    if (t.ds[1]) h[15:8] = t.d[15:8];
                    sdram[key] = h;
                    bus.rv_req_ack = ~bus.rv_req_ack;
                end else begin
                    bus.rv_req_ack = ~bus.rv_req_ack;
                    bus.rv_dout = ~h;
                    repeat (3) @(negedge clk);
                    bus.rv_dout = h;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit [31:0] ref_word(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic wait_ready(output logic [31:0] rd, output int cyc, output bit ok, output logic extra);
        ok = 1'b0; cyc = 0; rd = 32'h0;
        while (!ok && cyc < 500) begin
            @(posedge clk); #1; cyc++;
            if (bus.mem_ready === 1'b1) begin ok = 1'b1; rd = bus.mem_rdata; end
        end
        @(negedge clk); bus.mem_valid = 1'b0;
        @(posedge clk); #1; extra = bus.mem_ready;
    endtask

    task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int ntx, output int cyc,
                          output bit ok, output logic extra);
        int n0;
        n0 = tx_q.size();
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
        wait_ready(rd, cyc, ok, extra);
        ntx = tx_q.size() - n0;
    endtask

    task automatic test_reset();
        bus.mem_valid = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0; bus.sdram_busy = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if ({bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b rdata=%h addr=%h din=%h ds=%b we=%b req=%b want all 0",
                     bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req);
        end
        @(negedge clk); resetn = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if (bus.rv_req !== 1'b1) begin
            n_fail++; $display("FAIL resync_req: got %b want 1", bus.rv_req);
        end
        model_en = 1'b1;
        repeat (5) @(posedge clk); #1;
        n_tests++;
        if (bus.rv_req !== 1'b1 || tx_q.size() != 0) begin
            n_fail++; $display("FAIL idle_no_toggle: req=%b tx=%0d want 1 and 0", bus.rv_req, tx_q.size());
        end
    endtask

    task automatic test_full_read();
        logic [31:0] rd; int ntx, cyc, n0; bit ok; logic extra;
        sdram[32'h802] = 16'hBEEF; sdram[32'h803] = 16'hDEAD; ref_mem[32'h401] = 32'hDEADBEEF;
        ack_lat = 4; n0 = tx_q.size();
        cpu_op(32'h0000_1004, 32'h0, 4'h0, rd, ntx, cyc, ok, extra);
        rc_vld = 1'b1; rc_tag = 32'h401; last_rd = 32'hDEADBEEF;
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_read_data: ok=%0d got %h want deadbeef", ok, rd);
        end
        n_tests++;
        if (ntx != 2 || extra !== 1'b0) begin
            n_fail++; $display("FAIL full_read_count: tx=%0d extra_ready=%b want 2 and 0", ntx, extra);
        end else begin
            n_tests++;
            if (tx_q[n0].a !== 20'h00802 || tx_q[n0].ds !== 2'b11 || tx_q[n0].we !== 1'b0 ||
                tx_q[n0+1].a !== 20'h00803 || tx_q[n0+1].ds !== 2'b11 || tx_q[n0+1].we !== 1'b0) begin
                n_fail++;
                $display("FAIL full_read_tx: got %h/%b/%b %h/%b/%b want 00802/11/0 00803/11/0",
                         tx_q[n0].a, tx_q[n0].ds, tx_q[n0].we, tx_q[n0+1].a, tx_q[n0+1].ds, tx_q[n0+1].we);
            end
        end
    endtask

    task automatic test_write(input string name, input logic [3:0] s, input logic [19:0] ea,
                              input logic [15:0] ed, input logic [1:0] eds);
        logic [31:0] rd; int ntx, cyc, n0; bit ok; logic extra; bit [31:0] w;
        n0 = tx_q.size();
        cpu_op(32'h0000_0008, 32'h1234_5678, s, rd, ntx, cyc, ok, extra);
        w = ref_word(2);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = 8'(32'h1234_5678 >> (8*b));
        ref_mem[2] = w;
        n_tests++;
        if (!ok || ntx != 1 || rd !== last_rd) begin
            n_fail++; $display("FAIL %s_count: ok=%0d tx=%0d rdata=%h want 1 tx rdata=%h", name, ok, ntx, rd, last_rd);
        end else begin
            n_tests++;
            if (tx_q[n0].a !== ea || tx_q[n0].d !== ed || tx_q[n0].ds !== eds || tx_q[n0].we !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_tx: got %h/%h/%b/%b want %h/%h/%b/1", name,
                         tx_q[n0].a, tx_q[n0].d, tx_q[n0].ds, tx_q[n0].we, ea, ed, eds);
            end
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd; int cyc, n0; bit ok; logic extra, rq0;
        n0 = tx_q.size();
        @(negedge clk);
        bus.sdram_busy = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_0008; bus.mem_wstrb = 4'h0;
        rq0 = bus.rv_req;
        repeat (50) @(posedge clk); #1;
        n_tests++;
        if (bus.rv_req !== rq0 || tx_q.size() != n0) begin
            n_fail++; $display("FAIL busy_gate: req=%b tx=%0d want %b and %0d", bus.rv_req, tx_q.size(), rq0, n0);
        end
        @(negedge clk); bus.sdram_busy = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.rv_req !== rq0) begin
            n_fail++; $display("FAIL busy_early: req=%b want %b", bus.rv_req, rq0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.rv_req !== ~rq0) begin
            n_fail++; $display("FAIL busy_release_start: req=%b want %b", bus.rv_req, ~rq0);
        end
        bus.sdram_busy = 1'b1;
        wait_ready(rd, cyc, ok, extra);
        bus.sdram_busy = 1'b0;
        last_rd = ref_word(2); rc_vld = 1'b1; rc_tag = 2;
        n_tests++;
        if (!ok || rd !== last_rd || tx_q.size() != n0 + 2) begin
            n_fail++; $display("FAIL busy_read: ok=%0d rdata=%h tx=%0d want %h and 2 tx", ok, rd, tx_q.size() - n0, last_rd);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; int ntx, cyc, n0, rdy_seen; bit ok; logic extra;
        ack_lat = 6; n0 = tx_q.size();
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_1004; bus.mem_wstrb = 4'h0;
        for (int i = 0; i < 20 && tx_q.size() == n0; i++) @(negedge clk);
        @(negedge clk);
        resetn = 1'b0; bus.mem_valid = 1'b0; model_en = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b1;
        rc_vld = 1'b0; last_rd = 32'h0;
        rdy_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.mem_ready !== 1'b0) rdy_seen++;
        end
        n_tests++;
        if (rdy_seen != 0 || bus.rv_req !== bus.rv_req_ack) begin
            n_fail++; $display("FAIL reset_abandon: ready_cycles=%0d req=%b ack=%b want 0 and equal",
                               rdy_seen, bus.rv_req, bus.rv_req_ack);
        end
        model_en = 1'b1; ack_lat = 3;
        cpu_op(32'h0000_1004, 32'h0, 4'h0, rd, ntx, cyc, ok, extra);
        rc_vld = 1'b1; rc_tag = 32'h401; last_rd = 32'hDEADBEEF;
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF || ntx != 2) begin
            n_fail++; $display("FAIL read_after_reset: ok=%0d rdata=%h tx=%0d want deadbeef and 2", ok, rd, ntx);
        end
`ifdef SDRAM_RV_RDCACHE_EN
        cpu_op(32'h0000_1004, 32'h0, 4'h0, rd, ntx, cyc, ok, extra);
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF || ntx != 0 || cyc != 2) begin
            n_fail++; $display("FAIL cache_hit: ok=%0d rdata=%h tx=%0d cycles=%0d want deadbeef, 0, 2", ok, rd, ntx, cyc);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic [3:0] s; int ntx, cyc, idx, exp_tx; bit ok; logic extra; bit [31:0] w;
        for (int k = 0; k < 60; k++) begin
            idx = $urandom_range(0, 7);
            a = ($urandom() & 32'hFFE0_0003) | (idx << 2);
            d = $urandom();
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            ack_lat = $urandom_range(1, 5);
            if (s == 4'h0) begin
                exp_tx = 2;
`ifdef SDRAM_RV_RDCACHE_EN
                if (rc_vld && rc_tag == idx) exp_tx = 0;
`endif
            end else begin
                exp_tx = ((s[1:0] != 2'b00) ? 1 : 0) + ((s[3:2] != 2'b00) ? 1 : 0);
            end
            cpu_op(a, d, s, rd, ntx, cyc, ok, extra);
            if (s == 4'h0) begin
                last_rd = ref_word(idx); rc_vld = 1'b1; rc_tag = idx;
            end else begin
                w = ref_word(idx);
                for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
                ref_mem[idx] = w;
            end
            n_tests++;
            if (!ok || rd !== last_rd || ntx != exp_tx || extra !== 1'b0) begin
                n_fail++;
                $display("FAIL random_op%0d: addr=%h wstrb=%h ok=%0d rdata=%h tx=%0d extra=%b want rdata=%h tx=%0d",
                         k, a, s, ok, rd, ntx, extra, last_rd, exp_tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_read();
        test_write("partial_write", 4'b1100, 20'h00005, 16'h1234, 2'b11);
        test_write("byte_write",    4'b0001, 20'h00004, 16'h5678, 2'b01);
        test_busy();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
